// File: rtl/csr_issue_sequencer.sv
// CSR issue sequencer: admits one CSR op at a time, strobes writeback and commit,
// and holds issue for a fixed drain window after a serializing commit.
module csr_issue_sequencer #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned DRAIN_CYCLES  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic [XLEN-1:0]          issue_wdata_i,
  input  logic                     issue_serialize_i,
  output logic                     csr_valid_o,
  input  logic                     csr_ready_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  input  logic                     commit_csr_i,
  input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
  output logic                     csr_commit_o,
  output logic                     serialize_o,
  output logic                     commit_mismatch_o
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam bit HasDrain = (DRAIN_CYCLES > 0);
  localparam logic [CntW-1:0] DrainLoad = HasDrain ? CntW'(DRAIN_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    DRAIN       = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [TRANS_ID_BITS-1:0] id_q, id_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic                     ser_q, ser_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     wb_valid_q, wb_valid_d;

  logic ready_s, accept_s, id_match_s, commit_s, mismatch_s;

  // Handshake decode; rst_ni gating keeps the combinational strobes low during reset.
  always_comb begin
    ready_s    = rst_ni & (state_q == IDLE) & csr_ready_i & ~flush_i;
    accept_s   = issue_valid_i & ready_s;
    id_match_s = (commit_trans_id_i == id_q);
    commit_s   = rst_ni & (state_q == WAIT_COMMIT) & commit_csr_i & id_match_s;
    mismatch_s = rst_ni & (state_q == WAIT_COMMIT) & commit_csr_i & ~id_match_s;
  end

  // Next-state logic; flush overrides the sequence but never suppresses a commit.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    wdata_d    = wdata_q;
    ser_d      = ser_q;
    cnt_d      = cnt_q;
    wb_valid_d = accept_s;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = WAIT_COMMIT;
          id_d    = issue_trans_id_i;
          wdata_d = issue_wdata_i;
          ser_d   = issue_serialize_i;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_COMMIT: begin
        if (commit_s) begin
          if (ser_q && HasDrain) begin
            state_d = DRAIN;
            cnt_d   = DrainLoad;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT_COMMIT;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and pending-op registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      wdata_q    <= '0;
      ser_q      <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      wdata_q    <= wdata_d;
      ser_q      <= ser_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign issue_ready_o     = ready_s;
  assign csr_valid_o       = accept_s;
  assign wb_valid_o        = wb_valid_q & ~flush_i;
  assign wb_trans_id_o     = id_q;
  assign wb_result_o       = wdata_q;
  assign csr_commit_o      = commit_s;
  assign commit_mismatch_o = mismatch_s;
  assign serialize_o       = (state_q == DRAIN);

endmodule

// File: tb/tb_csr_issue_sequencer.sv
// Scoreboard bench for csr_issue_sequencer: writeback results are queued at accept
// and compared when due; control strobes are checked cycle by cycle.
module tb_csr_issue_sequencer;

  localparam int TIB = 3;
  localparam int XL  = 64;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           flush_i, issue_valid_i, issue_serialize_i, csr_ready_i, commit_csr_i;
  logic [TIB-1:0] issue_trans_id_i, commit_trans_id_i;
  logic [XL-1:0]  issue_wdata_i;
  logic           issue_ready_o, csr_valid_o, wb_valid_o, csr_commit_o, serialize_o;
  logic           commit_mismatch_o;
  logic [TIB-1:0] wb_trans_id_o;
  logic [XL-1:0]  wb_result_o;

  typedef struct {
    int            due;
    logic [TIB-1:0] id;
    logic [XL-1:0]  data;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int      n_checks = 0;
  int      n_errs   = 0;
  int      cyc_cnt  = 0;

  csr_issue_sequencer #(.TRANS_ID_BITS(TIB), .XLEN(XL), .DRAIN_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_trans_id_i(issue_trans_id_i), .issue_wdata_i(issue_wdata_i),
    .issue_serialize_i(issue_serialize_i), .csr_valid_o(csr_valid_o),
    .csr_ready_i(csr_ready_i), .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o), .commit_csr_i(commit_csr_i),
    .commit_trans_id_i(commit_trans_id_i), .csr_commit_o(csr_commit_o),
    .serialize_o(serialize_o), .commit_mismatch_o(commit_mismatch_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_cnt);
    end
  endtask

  // Writeback scoreboard: the due entry must appear unless the bench flushes that cycle.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc_cnt) begin
        wb_exp_t e;
        e = sb_q.pop_front();
        check_eq("wb_valid", {63'd0, wb_valid_o}, {63'd0, !flush_i});
        if (!flush_i) begin
          check_eq("wb_id", {61'd0, wb_trans_id_o}, {61'd0, e.id});
          check_eq("wb_data", wb_result_o, e.data);
        end
      end else if (wb_valid_o) begin
        check_eq("wb_spurious", 64'd1, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; issue_valid_i = 1'b0; issue_serialize_i = 1'b0;
    commit_csr_i = 1'b0; csr_ready_i = 1'b1;
  endtask

  // Offer an op this cycle and, when accept is expected, queue its writeback.
  task automatic offer(input logic [TIB-1:0] id, input logic [XL-1:0] d, input logic ser,
                       input logic exp_acc, input string tag);
    wb_exp_t e;
    issue_valid_i = 1'b1; issue_trans_id_i = id; issue_wdata_i = d; issue_serialize_i = ser;
    settle();
    check_eq({tag, "_csr_valid"}, {63'd0, csr_valid_o}, {63'd0, exp_acc});
    check_eq({tag, "_ready"}, {63'd0, issue_ready_o}, {63'd0, exp_acc});
    if (exp_acc) begin
      e.due = cyc_cnt + 1; e.id = id; e.data = d;
      sb_q.push_back(e);
    end
  endtask

  task automatic commit(input logic [TIB-1:0] id, input logic exp_c, input logic exp_m,
                        input string tag);
    commit_csr_i = 1'b1; commit_trans_id_i = id;
    settle();
    check_eq({tag, "_commit"}, {63'd0, csr_commit_o}, {63'd0, exp_c});
    check_eq({tag, "_mismatch"}, {63'd0, commit_mismatch_o}, {63'd0, exp_m});
  endtask

  task automatic expect_ctl(input logic rdy, input logic ser, input string tag);
    settle();
    check_eq({tag, "_ready"}, {63'd0, issue_ready_o}, {63'd0, rdy});
    check_eq({tag, "_serialize"}, {63'd0, serialize_o}, {63'd0, ser});
  endtask

  task automatic expect_all_zero(input string tag);
    settle();
    check_eq({tag, "_strobes"},
             {58'd0, issue_ready_o, csr_valid_o, wb_valid_o, csr_commit_o, serialize_o,
              commit_mismatch_o}, 64'd0);
    check_eq({tag, "_wb_id"}, {61'd0, wb_trans_id_o}, 64'd0);
    check_eq({tag, "_wb_data"}, wb_result_o, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [XL-1:0] d;
    rst_ni = 1'b0; idle_inputs();
    issue_trans_id_i = '0; issue_wdata_i = '0; commit_trans_id_i = '0;
    issue_valid_i = 1'b1; commit_csr_i = 1'b1;
    expect_all_zero("reset");
    idle_inputs();
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Basic op: accept at T, writeback at T+1, commit at T+3, ready at T+4.
    offer(3'd2, 64'hABCD, 1'b0, 1'b1, "basic_acc");
    tick(); issue_valid_i = 1'b0;
    expect_ctl(1'b0, 1'b0, "basic_wait");
    tick();
    tick(); commit(3'd2, 1'b1, 1'b0, "basic");
    tick(); commit_csr_i = 1'b0;
    expect_ctl(1'b1, 1'b0, "basic_after");

    // Serializing op: four drain cycles with issue held, including the commit cycle.
    d = {$urandom, $urandom};
    offer(3'd3, d, 1'b1, 1'b1, "ser_acc");
    tick(); issue_valid_i = 1'b0;
    tick(); issue_valid_i = 1'b1; issue_trans_id_i = 3'd4;
    commit(3'd3, 1'b1, 1'b0, "ser");
    check_eq("ser_commit_cycle_valid", {63'd0, csr_valid_o}, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(); commit_csr_i = 1'b0;
      expect_ctl(1'b0, 1'b1, $sformatf("drain%0d", k));
      check_eq("drain_csr_valid", {63'd0, csr_valid_o}, 64'd0);
    end
    tick(); issue_valid_i = 1'b0;
    expect_ctl(1'b1, 1'b0, "drain_done");

    // Mismatched commit holds state; a later matching commit succeeds.
    offer(3'd1, {$urandom, $urandom}, 1'b0, 1'b1, "mm_acc");
    tick(); issue_valid_i = 1'b0;
    commit(3'd5, 1'b0, 1'b1, "mm_bad");
    tick(); commit_csr_i = 1'b0;
    settle();
    check_eq("mm_pulse_end", {63'd0, commit_mismatch_o}, 64'd0);
    expect_ctl(1'b0, 1'b0, "mm_held");
    tick(); commit(3'd1, 1'b1, 1'b0, "mm_good");
    tick(); commit_csr_i = 1'b0;
    expect_ctl(1'b1, 1'b0, "mm_after");

    // Flush blocks the accept, then a flush right after an accept kills writeback.
    flush_i = 1'b1;
    offer(3'd6, 64'h1234, 1'b0, 1'b0, "fl_block");
    tick(); flush_i = 1'b0;
    offer(3'd6, 64'h1234, 1'b0, 1'b1, "fl_acc");
    tick(); issue_valid_i = 1'b0; flush_i = 1'b1;
    settle();
    check_eq("fl_wb_killed", {63'd0, wb_valid_o}, 64'd0);
    tick(); flush_i = 1'b0;
    expect_ctl(1'b1, 1'b0, "fl_idle");

    // Flush coinciding with a serializing commit: commit kept, drain skipped.
    offer(3'd6, {$urandom, $urandom}, 1'b1, 1'b1, "flc_acc");
    tick(); issue_valid_i = 1'b0;
    tick(); flush_i = 1'b1;
    commit(3'd6, 1'b1, 1'b0, "flc");
    tick(); flush_i = 1'b0; commit_csr_i = 1'b0;
    expect_ctl(1'b1, 1'b0, "flc_next");
    tick();
    expect_ctl(1'b1, 1'b0, "flc_next2");

    // Backpressure from the CSR buffer, accepted the cycle ready rises.
    csr_ready_i = 1'b0;
    offer(3'd4, 64'h55AA, 1'b0, 1'b0, "bp_hold");
    tick();
    offer(3'd4, 64'h55AA, 1'b0, 1'b0, "bp_hold2");
    tick(); csr_ready_i = 1'b1;
    offer(3'd4, 64'h55AA, 1'b0, 1'b1, "bp_acc");
    tick(); issue_valid_i = 1'b0;
    commit(3'd4, 1'b1, 1'b0, "bp");
    tick();
    // Commit while IDLE is ignored even with the last op's ID.
    commit(3'd4, 1'b0, 1'b0, "idle_commit");
    tick(); commit_csr_i = 1'b0;

    // Async reset in DRAIN, with commit in DRAIN ignored first.
    offer(3'd7, {$urandom, $urandom}, 1'b1, 1'b1, "rd_acc");
    tick(); issue_valid_i = 1'b0;
    commit(3'd7, 1'b1, 1'b0, "rd");
    tick();
    commit(3'd7, 1'b0, 1'b0, "drain_commit");
    expect_ctl(1'b0, 1'b1, "rd_drain");
    rst_ni = 1'b0;
    expect_all_zero("rst_drain");
    tick(); commit_csr_i = 1'b0; rst_ni = 1'b1;
    expect_ctl(1'b1, 1'b0, "rd_idle");

    // Async reset in WAIT_COMMIT with inputs that would otherwise strobe.
    offer(3'd5, {$urandom, $urandom}, 1'b0, 1'b1, "rw_acc");
    tick(); issue_valid_i = 1'b0;
    tick(); issue_valid_i = 1'b1;
    commit(3'd5, 1'b1, 1'b0, "rw_pre");
    rst_ni = 1'b0;
    expect_all_zero("rst_wait");
    tick(); idle_inputs(); rst_ni = 1'b1;
    expect_ctl(1'b1, 1'b0, "rw_idle");

    tick(); tick();
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
